// File: rtl/loop_back_router.sv
// Per-channel west/east loopback router: write merge, read steer, return merge.
module loop_back_router #(
  parameter int         N_CH     = 8,
  parameter int         CMD_W    = 64,
  parameter int         DATA_W   = 512,
  parameter int         RQ_DEPTH = 4,
  parameter logic [1:0] EAST_DIR = 2'd1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH-1:0]          w_wr_vld,
  output logic [N_CH-1:0]          w_wr_rdy,
  input  logic [N_CH*CMD_W-1:0]    w_wr_cmd,
  input  logic [N_CH*DATA_W-1:0]   w_wr_data,
  input  logic [N_CH-1:0]          e_wr_vld,
  output logic [N_CH-1:0]          e_wr_rdy,
  input  logic [N_CH*CMD_W-1:0]    e_wr_cmd,
  input  logic [N_CH*DATA_W-1:0]   e_wr_data,
  output logic [N_CH-1:0]          s_wr_vld,
  input  logic [N_CH-1:0]          s_wr_rdy,
  output logic [N_CH*CMD_W-1:0]    s_wr_cmd,
  output logic [N_CH*DATA_W-1:0]   s_wr_data,
  input  logic [N_CH-1:0]          w_rd_vld,
  output logic [N_CH-1:0]          w_rd_rdy,
  input  logic [N_CH*CMD_W-1:0]    w_rd_cmd,
  input  logic [N_CH*2-1:0]        w_rd_dir,
  output logic [N_CH-1:0]          s_rd_vld,
  input  logic [N_CH-1:0]          s_rd_rdy,
  output logic [N_CH*CMD_W-1:0]    s_rd_cmd,
  output logic [N_CH-1:0]          e_rd_vld,
  input  logic [N_CH-1:0]          e_rd_rdy,
  output logic [N_CH*CMD_W-1:0]    e_rd_cmd,
  input  logic [N_CH-1:0]          s_rdata_vld,
  input  logic [N_CH*DATA_W-1:0]   s_rdata,
  input  logic [N_CH-1:0]          e_rdata_vld,
  output logic [N_CH-1:0]          e_rdata_rdy,
  input  logic [N_CH*DATA_W-1:0]   e_rdata,
  output logic [N_CH-1:0]          w_rdata_vld,
  output logic [N_CH*DATA_W-1:0]   w_rdata
);

  localparam int         AW       = $clog2(RQ_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(RQ_DEPTH);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    // write merge slot
    logic              wr_vld_q, wr_vld_d, ptr_q, ptr_d, wr_free, gnt_w, gnt_e;
    logic [CMD_W-1:0]  wr_cmd_q, wr_cmd_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    // read steer slots
    logic              to_east, rde_free, rds_free, rd_acc;
    logic              rde_vld_q, rde_vld_d, rds_vld_q, rds_vld_d;
    logic [CMD_W-1:0]  rde_cmd_q, rde_cmd_d, rds_cmd_q, rds_cmd_d;
    // return merge
    logic [DATA_W-1:0] mem_q [RQ_DEPTH];
    logic [AW-1:0]     wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic              full, push, pop, rv_q, rv_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // Write arbitration: round-robin pointer only consulted when both sides are valid.
    always_comb begin
      wr_free   = !wr_vld_q || s_wr_rdy[c];
      gnt_w     = wr_free && w_wr_vld[c] && !(e_wr_vld[c] && ptr_q);
      gnt_e     = wr_free && e_wr_vld[c] && !(w_wr_vld[c] && !ptr_q);
      wr_vld_d  = wr_free ? (gnt_w || gnt_e) : 1'b1;
      wr_cmd_d  = wr_cmd_q;
      wr_data_d = wr_data_q;
      ptr_d     = ptr_q;
      if (gnt_w) begin
        wr_cmd_d  = w_wr_cmd[c*CMD_W +: CMD_W];
        wr_data_d = w_wr_data[c*DATA_W +: DATA_W];
      end else if (gnt_e) begin
        wr_cmd_d  = e_wr_cmd[c*CMD_W +: CMD_W];
        wr_data_d = e_wr_data[c*DATA_W +: DATA_W];
      end
      if (wr_free && w_wr_vld[c] && e_wr_vld[c]) ptr_d = ~ptr_q;
    end

    // Read steering: each target has its own slot, a read goes to exactly one.
    always_comb begin
      to_east   = (w_rd_dir[c*2 +: 2] == EAST_DIR);
      rde_free  = !rde_vld_q || e_rd_rdy[c];
      rds_free  = !rds_vld_q || s_rd_rdy[c];
      rd_acc    = w_rd_vld[c] && (to_east ? rde_free : rds_free);
      rde_vld_d = rde_free ? (rd_acc && to_east) : 1'b1;
      rds_vld_d = rds_free ? (rd_acc && !to_east) : 1'b1;
      rde_cmd_d = rde_cmd_q;
      rds_cmd_d = rds_cmd_q;
      if (rd_acc && to_east)  rde_cmd_d = w_rd_cmd[c*CMD_W +: CMD_W];
      if (rd_acc && !to_east) rds_cmd_d = w_rd_cmd[c*CMD_W +: CMD_W];
    end

    // Return merge: local data wins, east data waits in the FIFO.
    always_comb begin
      full    = (cnt_q == FULL_CNT);
      push    = e_rdata_vld[c] && !full;
      pop     = !s_rdata_vld[c] && (cnt_q != '0);
      wp_d    = push ? wp_q + AW'(1) : wp_q;
      rp_d    = pop ? rp_q + AW'(1) : rp_q;
      cnt_d   = cnt_q;
      if (push && !pop) cnt_d = cnt_q + (AW+1)'(1);
      if (pop && !push) cnt_d = cnt_q - (AW+1)'(1);
      rv_d    = s_rdata_vld[c] || (cnt_q != '0);
      rdata_d = rdata_q;
      if (s_rdata_vld[c]) rdata_d = s_rdata[c*DATA_W +: DATA_W];
      else if (pop)       rdata_d = mem_q[rp_q];
    end

    // Control state: cleared asynchronously so valids drop immediately on reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_vld_q  <= 1'b0;
        ptr_q     <= 1'b0;
        rde_vld_q <= 1'b0;
        rds_vld_q <= 1'b0;
        wp_q      <= '0;
        rp_q      <= '0;
        cnt_q     <= '0;
        rv_q      <= 1'b0;
      end else begin
        wr_vld_q  <= wr_vld_d;
        ptr_q     <= ptr_d;
        rde_vld_q <= rde_vld_d;
        rds_vld_q <= rds_vld_d;
        wp_q      <= wp_d;
        rp_q      <= rp_d;
        cnt_q     <= cnt_d;
        rv_q      <= rv_d;
      end
    end

    // Payload registers and FIFO storage carry no reset; they are qualified by valids.
    always_ff @(posedge clk) begin
      wr_cmd_q  <= wr_cmd_d;
      wr_data_q <= wr_data_d;
      rde_cmd_q <= rde_cmd_d;
      rds_cmd_q <= rds_cmd_d;
      rdata_q   <= rdata_d;
      if (push) mem_q[wp_q] <= e_rdata[c*DATA_W +: DATA_W];
    end

    assign w_wr_rdy[c]                    = wr_free && !(e_wr_vld[c] && ptr_q);
    assign e_wr_rdy[c]                    = wr_free && !(w_wr_vld[c] && !ptr_q);
    assign s_wr_vld[c]                    = wr_vld_q;
    assign s_wr_cmd[c*CMD_W +: CMD_W]     = wr_cmd_q;
    assign s_wr_data[c*DATA_W +: DATA_W]  = wr_data_q;
    assign w_rd_rdy[c]                    = to_east ? rde_free : rds_free;
    assign e_rd_vld[c]                    = rde_vld_q;
    assign e_rd_cmd[c*CMD_W +: CMD_W]     = rde_cmd_q;
    assign s_rd_vld[c]                    = rds_vld_q;
    assign s_rd_cmd[c*CMD_W +: CMD_W]     = rds_cmd_q;
    assign e_rdata_rdy[c]                 = !full;
    assign w_rdata_vld[c]                 = rv_q;
    assign w_rdata[c*DATA_W +: DATA_W]    = rdata_q;
  end

endmodule
